instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the multicycle control unit.
- Owns the program counter and the instruction register.
- Runs the memory read handshake for instruction fetch.
- Presents decoded instruction fields (opcode, register addresses, immediate) with a one-cycle valid pulse, which the control unit consumes to sequence decode/execute.

Parameters:
WORD_SIZE, 16, instruction/data/PC width
REG_ADDR_SIZE, 3, register-address field width
RESET_PC, 16'h0000, PC value after reset
TIMEOUT_CYCLES, 15, wait-cycle limit (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  control unit requests next instruction (level, sampled in IDLE)
pc_load  in  1  load PC with pc_load_value (branch/jump)
pc_load_value  in  WORD_SIZE  new PC value
mem_addr  out  WORD_SIZE  fetch address, registered
mem_rd_req  out  1  memory read request, registered
mem_rd_ack  in  1  memory has data on mem_rd_data this cycle
mem_rd_data  in  WORD_SIZE  instruction word from memory
instr_valid  out  1  one-cycle pulse: new IR contents available
opcode  out  5  IR[15:11]
rd_addr  out  REG_ADDR_SIZE  IR[10:8]
rs_addr  out  REG_ADDR_SIZE  IR[7:5]
imm  out  WORD_SIZE  IR[7:0], sign-extended
pc  out  WORD_SIZE  current PC (address of next instruction to fetch)
busy  out  1  high while in WAIT
fetch_err  out  1  one-cycle timeout pulse (optional feature)

Behaviour:
- Reset (rst_n low, async):
  - pc=RESET_PC, IR=0, state=IDLE.
  - mem_rd_req=0, mem_addr=RESET_PC, instr_valid=0, busy=0, fetch_err=0.
- States: IDLE, WAIT.
- IDLE:
  - pc_load=1 -> pc<=pc_load_value; fetch_req ignored that cycle (load has priority).
  - Else fetch_req=1 -> state<=WAIT, mem_rd_req<=1, mem_addr<=pc, busy<=1.
- WAIT:
  - mem_rd_req and mem_addr held stable until ack.
  - mem_rd_ack=1 -> IR<=mem_rd_data; pc<=pc+1 (modulo 2^WORD_SIZE, 16'hFFFF wraps to 0); mem_rd_req<=0; busy<=0; instr_valid<=1 for exactly one cycle; state<=IDLE.
  - fetch_req and pc_load are ignored in WAIT.
- mem_rd_ack while mem_rd_req=0 is ignored; IR is unchanged.
- Latency:
  - fetch_req high at edge N -> mem_rd_req high after edge N.
  - Ack sampled at edge M -> IR, pc and instr_valid updated after edge M.
  - Minimum fetch is 2 cycles from fetch_req to instr_valid.
- Back-to-back fetches: fetch_req held high through instr_valid restarts a fetch the cycle after return to IDLE, using the incremented pc.
- Field outputs are combinational from IR and stable until the next accepted ack.
- Reset mid-WAIT aborts the fetch immediately: req drops asynchronously and no instr_valid is produced.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: mem_rd_req<=0, busy<=0, fetch_err pulses one cycle, IR and pc unchanged, state<=IDLE.
  - Ack arriving in the same cycle as the limit wins: normal completion, no error.
- Not defined: no counter logic; fetch_err tied 0; WAIT lasts indefinitely.

Decomposition:
- Shared package cpu_pkg:
  - WORD_SIZE, REG_ADDR_SIZE, OPCODE_SIZE=5.
  - Field bit positions (OPCODE_MSB/LSB, RD_MSB/LSB, RS_MSB/LSB, IMM_MSB/LSB).
  - Fetch-state encoding constants (IDLE=0, WAIT=1).
- Sub-module instr_field_decoder (combinational IR -> opcode/rd/rs/imm), reused later by the decode stage.

Test Plan:
- Reset: hold rst_n=0 mid-run with mem_rd_req=1 -> all outputs read reset values immediately; pc=16'h0000; no instr_valid after release.
- Zero-wait fetch: fetch_req=1, ack in first req cycle with data 16'hA9E5 -> instr_valid one cycle; opcode=5'b10101, rd_addr=3'b001, rs_addr=3'b111, imm=16'hFFE5; pc=1.
- Wait states: ack after 3 req cycles -> mem_addr stable, mem_rd_req held 3 cycles, IR unchanged until ack, pc increments once.
- PC wrap and load priority:
  - pc_load=1 with value 16'hFFFF and fetch_req=1 in the same IDLE cycle -> no req that cycle.
  - Next fetch uses mem_addr=16'hFFFF; after ack, pc=16'h0000.
- Stray signals: mem_rd_ack pulses while idle, and pc_load pulses during WAIT -> IR and pc unaffected; in-flight fetch completes at the original address.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, no ack -> fetch_err pulses after 15 WAIT cycles, req drops, pc unchanged; ack on the 15th cycle instead -> normal completion, fetch_err=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction fetch unit and later pipeline stages:
// datapath widths, instruction field bit positions and the fetch-state
// encoding. No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int WORD_SIZE     = 16;
    localparam int REG_ADDR_SIZE = 3;
    localparam int OPCODE_SIZE   = 5;

    // Instruction word layout: [15:11] opcode, [10:8] rd, [7:5] rs, [7:0] imm.
    // rs and imm overlap on purpose; the opcode decides which one is meaningful.
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 11;
    localparam int RD_MSB     = 10;
    localparam int RD_LSB     = 8;
    localparam int RS_MSB     = 7;
    localparam int RS_LSB     = 5;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory read bus between the fetch unit (master) and memory
// (slave).
//   mem_addr    master->slave  fetch address
//   mem_rd_req  master->slave  read request, held until acknowledged
//   mem_rd_ack  slave->master  read data valid this cycle
//   mem_rd_data slave->master  instruction word
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int WORD_SIZE = cpu_pkg::WORD_SIZE
);
    logic [WORD_SIZE-1:0] mem_addr;
    logic                 mem_rd_req;
    logic                 mem_rd_ack;
    logic [WORD_SIZE-1:0] mem_rd_data;

    modport master (
        output mem_addr,
        output mem_rd_req,
        input  mem_rd_ack,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_req,
        output mem_rd_ack,
        output mem_rd_data
    );
endinterface

// File: rtl/instr_field_decoder.sv
// -----------------------------------------------------------------------------
// instr_field_decoder
// Purely combinational split of an instruction word into its fields.
//   ir       in   instruction word
//   opcode   out  ir[15:11]
//   rd_addr  out  ir[10:8]
//   rs_addr  out  ir[7:5]
//   imm      out  ir[7:0] sign-extended to WORD_SIZE
// -----------------------------------------------------------------------------
module instr_field_decoder
    import cpu_pkg::*;
#(
    parameter int WORD_SIZE     = cpu_pkg::WORD_SIZE,
    parameter int REG_ADDR_SIZE = cpu_pkg::REG_ADDR_SIZE
) (
    input  logic [WORD_SIZE-1:0]     ir,
    output logic [OPCODE_SIZE-1:0]   opcode,
    output logic [REG_ADDR_SIZE-1:0] rd_addr,
    output logic [REG_ADDR_SIZE-1:0] rs_addr,
    output logic [WORD_SIZE-1:0]     imm
);
    localparam int IMM_W = IMM_MSB - IMM_LSB + 1;

    assign opcode  = ir[OPCODE_MSB:OPCODE_LSB];
    assign rd_addr = ir[RD_MSB:RD_LSB];
    assign rs_addr = ir[RS_MSB:RS_LSB];
    assign imm     = {{(WORD_SIZE - IMM_W){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Owns the PC and instruction register, runs the instruction-memory read
// handshake and presents decoded fields with a one-cycle instr_valid pulse.
// Optional macro FETCH_TIMEOUT_EN: abandons a fetch after TIMEOUT_CYCLES
// unacknowledged wait cycles and pulses fetch_err; otherwise WAIT is unbounded
// and fetch_err is tied low.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   fetch_req         request next instruction (sampled in IDLE)
//   pc_load/_value    load PC (IDLE only, has priority over fetch_req)
//   mem               instruction-memory bus (master side)
//   instr_valid       one-cycle pulse when new IR contents are available
//   opcode/rd_addr/rs_addr/imm  fields decoded from IR
//   pc                address of the next instruction to fetch
//   busy              high while a fetch is outstanding
//   fetch_err         one-cycle timeout pulse
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                   WORD_SIZE      = cpu_pkg::WORD_SIZE,
    parameter int                   REG_ADDR_SIZE  = cpu_pkg::REG_ADDR_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC       = '0,
    parameter int                   TIMEOUT_CYCLES = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_req,
    input  logic                     pc_load,
    input  logic [WORD_SIZE-1:0]     pc_load_value,
    instr_fetch_unit_if.master       mem,
    output logic                     instr_valid,
    output logic [OPCODE_SIZE-1:0]   opcode,
    output logic [REG_ADDR_SIZE-1:0] rd_addr,
    output logic [REG_ADDR_SIZE-1:0] rs_addr,
    output logic [WORD_SIZE-1:0]     imm,
    output logic [WORD_SIZE-1:0]     pc,
    output logic                     busy,
    output logic                     fetch_err
);
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    fetch_state_t         state, state_nxt;
    logic [WORD_SIZE-1:0] ir, ir_nxt;
    logic [WORD_SIZE-1:0] pc_nxt;
    logic [WORD_SIZE-1:0] addr_nxt;
    logic                 req_nxt;
    logic                 busy_nxt;
    logic                 valid_nxt;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // cnt holds the number of completed unacknowledged WAIT cycles, so the
    // limit is hit in the WAIT cycle where cnt == TIMEOUT_CYCLES-1.
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            ir             <= '0;
            mem.mem_addr   <= RESET_PC;
            mem.mem_rd_req <= 1'b0;
            busy           <= 1'b0;
            instr_valid    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt            <= '0;
            fetch_err      <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            ir             <= ir_nxt;
            mem.mem_addr   <= addr_nxt;
            mem.mem_rd_req <= req_nxt;
            busy           <= busy_nxt;
            instr_valid    <= valid_nxt;
`ifdef FETCH_TIMEOUT_EN
            cnt            <= cnt_nxt;
            fetch_err      <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        addr_nxt  = mem.mem_addr;
        req_nxt   = mem.mem_rd_req;
        busy_nxt  = busy;
        valid_nxt = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pc_load) begin
                    pc_nxt = pc_load_value;
                end else if (fetch_req) begin
                    state_nxt = WAIT;
                    req_nxt   = 1'b1;
                    addr_nxt  = pc;
                    busy_nxt  = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            WAIT: begin
                // Ack has priority over the timeout limit in the same cycle.
                if (mem.mem_rd_ack) begin
                    ir_nxt    = mem.mem_rd_data;
                    pc_nxt    = pc + WORD_SIZE'(1);
                    req_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                    valid_nxt = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    req_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifndef FETCH_TIMEOUT_EN
    assign fetch_err = 1'b0;
`endif

    instr_field_decoder #(
        .WORD_SIZE    (WORD_SIZE),
        .REG_ADDR_SIZE(REG_ADDR_SIZE)
    ) u_decoder (
        .ir     (ir),
        .opcode (opcode),
        .rd_addr(rd_addr),
        .rs_addr(rs_addr),
        .imm    (imm)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit. Expected fetch results are queued
// when the memory ack is driven and popped when instr_valid appears.
// Build with +define+FETCH_TIMEOUT_EN to exercise the timeout path.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_req = 1'b0;
    logic          pc_load = 1'b0;
    logic [W-1:0]  pc_load_value = '0;
    logic          instr_valid;
    logic [4:0]    opcode;
    logic [2:0]    rd_addr;
    logic [2:0]    rs_addr;
    logic [W-1:0]  imm;
    logic [W-1:0]  pc;
    logic          busy;
    logic          fetch_err;

    instr_fetch_unit_if #(.WORD_SIZE(W)) mem ();

    instr_fetch_unit #(
        .WORD_SIZE     (W),
        .REG_ADDR_SIZE (3),
        .RESET_PC      (16'h0000),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_req    (fetch_req),
        .pc_load      (pc_load),
        .pc_load_value(pc_load_value),
        .mem          (mem),
        .instr_valid  (instr_valid),
        .opcode       (opcode),
        .rd_addr      (rd_addr),
        .rs_addr      (rs_addr),
        .imm          (imm),
        .pc           (pc),
        .busy         (busy),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]   op;
        logic [2:0]   rd;
        logic [2:0]   rs;
        logic [W-1:0] imm;
        logic [W-1:0] pc;
    } exp_t;

    exp_t         sb[$];
    exp_t         last;
    logic [W-1:0] exp_pc;
    int           checks = 0;
    int           failures = 0;

    function automatic exp_t model(input logic [W-1:0] word, input logic [W-1:0] npc);
        exp_t e;
        e.op  = word[15:11];
        e.rd  = word[10:8];
        e.rs  = word[7:5];
        e.imm = {{8{word[7]}}, word[7:0]};
        e.pc  = npc;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t g;
        g.op  = opcode;
        g.rd  = rd_addr;
        g.rs  = rs_addr;
        g.imm = imm;
        g.pc  = pc;
        return g;
    endfunction

    // One complete fetch: request, `waits` unacknowledged cycles, then ack.
    task automatic do_fetch(input logic [W-1:0] word, input int waits, input bit stray_load);
        exp_t e;
        exp_t g;
        @(negedge clk);
        fetch_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        checks++;
        if (mem.mem_rd_req !== 1'b1 || mem.mem_addr !== exp_pc || busy !== 1'b1 || instr_valid !== 1'b0)
            begin
            failures++;
            $display("FAIL fetch_start req=%b addr=%h busy=%b valid=%b expected req=1 addr=%h busy=1 valid=0",
                     mem.mem_rd_req, mem.mem_addr, busy, instr_valid, exp_pc);
        end
        for (int i = 0; i < waits; i++) begin
            if (stray_load && i == 0) begin
                pc_load       = 1'b1;
                pc_load_value = 16'h5555;
                fetch_req     = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            pc_load   = 1'b0;
            fetch_req = 1'b0;
            g = observed();
            checks++;
            if (mem.mem_rd_req !== 1'b1 || mem.mem_addr !== exp_pc || instr_valid !== 1'b0 ||
                fetch_err !== 1'b0 || g.op !== last.op || g.rd !== last.rd || g.rs !== last.rs ||
                g.imm !== last.imm || g.pc !== exp_pc) begin
                failures++;
                $display("FAIL wait_hold cycle=%0d req=%b addr=%h valid=%b err=%b fields=%h expected req=1 addr=%h valid=0 err=0 fields=%h",
                         i, mem.mem_rd_req, mem.mem_addr, instr_valid, fetch_err, g,
                         exp_pc, {last.op, last.rd, last.rs, last.imm, exp_pc});
            end
        end
        mem.mem_rd_ack  = 1'b1;
        mem.mem_rd_data = word;
        sb.push_back(model(word, exp_pc + 16'd1));
        @(posedge clk);
        @(negedge clk);
        mem.mem_rd_ack = 1'b0;
        e = sb.pop_front();
        g = observed();
        checks++;
        if (instr_valid !== 1'b1 || g !== e || mem.mem_rd_req !== 1'b0 || busy !== 1'b0 || fetch_err !== 1'b0)
            begin
            failures++;
            $display("FAIL fetch_result valid=%b fields=%h req=%b busy=%b err=%b expected valid=1 fields=%h req=0 busy=0 err=0",
                     instr_valid, g, mem.mem_rd_req, busy, fetch_err, e);
        end
        last   = e;
        exp_pc = e.pc;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_pulse valid=%b expected 0", instr_valid);
        end
    endtask

    task automatic test_reset_initial();
        #1;
        checks++;
        if (pc !== 16'h0000 || mem.mem_rd_req !== 1'b0 || mem.mem_addr !== 16'h0000 || instr_valid !== 1'b0 ||
            busy !== 1'b0 || fetch_err !== 1'b0 || opcode !== 5'd0 || imm !== 16'h0000) begin
            failures++;
            $display("FAIL reset_initial pc=%h req=%b addr=%h valid=%b busy=%b err=%b op=%h imm=%h expected all zero",
                     pc, mem.mem_rd_req, mem.mem_addr, instr_valid, busy, fetch_err, opcode, imm);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 16'h0000;
        last   = '0;
    endtask

    task automatic test_zero_wait();
        do_fetch(16'hA9E5, 0, 1'b0);
        checks++;
        if (opcode !== 5'b10101 || rd_addr !== 3'b001 || rs_addr !== 3'b111 || imm !== 16'hFFE5 || pc !== 16'h0001)
            begin
            failures++;
            $display("FAIL zero_wait_fields op=%b rd=%b rs=%b imm=%h pc=%h expected op=10101 rd=001 rs=111 imm=ffe5 pc=0001",
                     opcode, rd_addr, rs_addr, imm, pc);
        end
    endtask

    task automatic test_wait_states();
        do_fetch(16'h3A40, 3, 1'b0);
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        fetch_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        checks++;
        if (mem.mem_rd_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_precondition req=%b expected 1", mem.mem_rd_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 16'h0000 || mem.mem_rd_req !== 1'b0 || mem.mem_addr !== 16'h0000 || instr_valid !== 1'b0 ||
            busy !== 1'b0 || opcode !== 5'd0 || imm !== 16'h0000) begin
            failures++;
            $display("FAIL reset_midrun pc=%h req=%b addr=%h valid=%b busy=%b op=%h imm=%h expected all zero",
                     pc, mem.mem_rd_req, mem.mem_addr, instr_valid, busy, opcode, imm);
        end
        mem.mem_rd_ack  = 1'b1;
        mem.mem_rd_data = 16'hBEEF;
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 16'h0000;
        last   = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            mem.mem_rd_ack = 1'b0;
            checks++;
            if (instr_valid !== 1'b0 || pc !== 16'h0000 || mem.mem_rd_req !== 1'b0) begin
                failures++;
                $display("FAIL reset_release cycle=%0d valid=%b pc=%h req=%b expected valid=0 pc=0000 req=0",
                         i, instr_valid, pc, mem.mem_rd_req);
            end
        end
    endtask

    task automatic test_wrap_load();
        @(negedge clk);
        pc_load       = 1'b1;
        pc_load_value = 16'hFFFF;
        fetch_req     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pc_load   = 1'b0;
        fetch_req = 1'b0;
        checks++;
        if (mem.mem_rd_req !== 1'b0 || busy !== 1'b0 || pc !== 16'hFFFF) begin
            failures++;
            $display("FAIL load_priority req=%b busy=%b pc=%h expected req=0 busy=0 pc=ffff",
                     mem.mem_rd_req, busy, pc);
        end
        exp_pc = 16'hFFFF;
        do_fetch(16'h0803, 1, 1'b0);
        checks++;
        if (pc !== 16'h0000 || imm !== 16'h0003) begin
            failures++;
            $display("FAIL pc_wrap pc=%h imm=%h expected pc=0000 imm=0003", pc, imm);
        end
    endtask

    task automatic test_stray_signals();
        @(negedge clk);
        mem.mem_rd_ack  = 1'b1;
        mem.mem_rd_data = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        mem.mem_rd_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc !== exp_pc || opcode !== last.op || imm !== last.imm) begin
            failures++;
            $display("FAIL stray_ack valid=%b pc=%h op=%h imm=%h expected valid=0 pc=%h op=%h imm=%h",
                     instr_valid, pc, opcode, imm, exp_pc, last.op, last.imm);
        end
        do_fetch(16'h7F7F, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t g;
        logic [W-1:0] words [3];
        words[0] = 16'h1111;
        words[1] = 16'hC2A8;
        words[2] = 16'h5F80;
        @(negedge clk);
        fetch_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (mem.mem_rd_req !== 1'b1 || mem.mem_addr !== exp_pc || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_start n=%0d req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                         k, mem.mem_rd_req, mem.mem_addr, instr_valid, exp_pc);
            end
            mem.mem_rd_ack  = 1'b1;
            mem.mem_rd_data = words[k];
            sb.push_back(model(words[k], exp_pc + 16'd1));
            @(posedge clk);
            @(negedge clk);
            mem.mem_rd_ack = 1'b0;
            if (k == 2) fetch_req = 1'b0;
            e = sb.pop_front();
            g = observed();
            checks++;
            if (instr_valid !== 1'b1 || g !== e) begin
                failures++;
                $display("FAIL b2b_result n=%0d valid=%b fields=%h expected valid=1 fields=%h",
                         k, instr_valid, g, e);
            end
            last   = e;
            exp_pc = e.pc;
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem.mem_rd_req !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop req=%b valid=%b expected req=0 valid=0", mem.mem_rd_req, instr_valid);
        end
    endtask

    task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
        exp_t g;
        @(negedge clk);
        fetch_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            checks++;
            if (mem.mem_rd_req !== 1'b1 || fetch_err !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL timeout_wait cycle=%0d req=%b err=%b busy=%b expected req=1 err=0 busy=1",
                         i, mem.mem_rd_req, fetch_err, busy);
            end
            @(posedge clk);
            @(negedge clk);
        end
        g = observed();
        checks++;
        if (fetch_err !== 1'b1 || mem.mem_rd_req !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0 ||
            g !== {last.op, last.rd, last.rs, last.imm, exp_pc}) begin
            failures++;
            $display("FAIL timeout_fire err=%b req=%b busy=%b valid=%b fields=%h expected err=1 req=0 busy=0 valid=0 fields=%h",
                     fetch_err, mem.mem_rd_req, busy, instr_valid, g, {last.op, last.rd, last.rs, last.imm, exp_pc});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (fetch_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse err=%b expected 0", fetch_err);
        end
        do_fetch(16'hC0FF, 14, 1'b0);
`else
        do_fetch(16'h4242, 20, 1'b0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        mem.mem_rd_ack  = 1'b0;
        mem.mem_rd_data = '0;
        test_reset_initial();
        test_zero_wait();
        test_wait_states();
        test_reset_midrun();
        test_wrap_load();
        test_stray_signals();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
